// File: rtl/codec_audio_pkg.sv
// Shared types and helpers for the stereo serial-audio transceiver.
// Holds the framing-mode enum and the MSB slot-position rule for each mode.
package codec_audio_pkg;

    typedef enum logic [1:0] {
        MODE_I2S = 2'd0,
        MODE_LJ  = 2'd1,
        MODE_RJ  = 2'd2
    } audio_mode_e;

    // The unused encoding 3 falls back to I2S framing.
    function automatic audio_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_LJ;
            2'd2:    return MODE_RJ;
            default: return MODE_I2S;
        endcase
    endfunction

    function automatic int unsigned msb_slot(input audio_mode_e mode,
                                             input int unsigned data_w,
                                             input int unsigned slot_w);
        case (mode)
            MODE_LJ: return 0;
            MODE_RJ: return slot_w - data_w;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/audio_bclk_lrck_gen.sv
// Bit-clock divider and slot/channel counter for the codec serial link.
// Produces BCLK, the channel bit (LRCK) and single-cycle rise/fall/frame strobes.
module audio_bclk_lrck_gen #(
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned BCLK_DIV = 2,
    parameter int unsigned CNT_W    = $clog2(SLOT_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic             o_bclk,
    output logic             o_ch,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic [CNT_W-1:0] o_bit_nxt,
    output logic             o_ch_nxt,
    output logic             o_rise_stb,
    output logic             o_fall_stb,
    output logic             o_frame_stb
);

    localparam int unsigned      DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(SLOT_W - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic             r_ch;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_div_wrap;
    logic             w_bit_wrap;

    assign w_div_wrap  = i_en && (r_div_cnt == DIV_LAST);
    assign w_bit_wrap  = (r_bit_cnt == BIT_LAST);
    assign o_rise_stb  = w_div_wrap && !r_bclk;
    assign o_fall_stb  = w_div_wrap && r_bclk;
    assign o_frame_stb = o_fall_stb && w_bit_wrap && r_ch;
    assign o_bit_nxt   = w_bit_wrap ? '0 : r_bit_cnt + 1'b1;
    assign o_ch_nxt    = r_ch ^ w_bit_wrap;

    assign o_bclk      = r_bclk;
    assign o_ch        = r_ch;
    assign o_bit_cnt   = r_bit_cnt;

    // Reset parks the counter on the last right-channel bit so the first
    // falling BCLK edge is also the first frame start.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
            r_bit_cnt <= BIT_LAST;
            r_ch      <= 1'b1;
        end else if (i_en) begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
            if (w_div_wrap) begin
                r_bclk <= ~r_bclk;
            end
            if (o_fall_stb) begin
                r_bit_cnt <= o_bit_nxt;
                r_ch      <= o_ch_nxt;
            end
        end
    end

endmodule

// File: rtl/codec_i2s_stereo_transceiver.sv
// Stereo serial-audio master for the codec path: I2S / LJ / RJ framing,
// valid/ready transmit holding register with underrun replay, per-frame RX strobe.
module codec_i2s_stereo_transceiver
    import codec_audio_pkg::*;
#(
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned BCLK_DIV = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] tx_left_i,
    input  logic [DATA_W-1:0] tx_right_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_left_o,
    output logic [DATA_W-1:0] rx_right_o,
    output logic              rx_valid_o,
    output logic              underrun_o,
    output logic              codec_bclk_o,
    output logic              codec_lrck_o,
    output logic              codec_dac_dat_o,
    input  logic              codec_adc_dat_i
);

    localparam int unsigned CNT_W = $clog2(SLOT_W);

    logic              w_bclk;
    logic              w_ch;
    logic              w_ch_nxt;
    logic [CNT_W-1:0]  w_bit_cnt;
    logic [CNT_W-1:0]  w_bit_nxt;
    logic              w_rise;
    logic              w_fall;
    logic              w_frame;

    logic              w_accept;
    logic [DATA_W-1:0] w_new_l;
    logic [DATA_W-1:0] w_new_r;
    logic [DATA_W-1:0] w_dac_word;
    logic [DATA_W-1:0] w_dac_shift;
    audio_mode_e       w_mode_eff;
    int                w_dac_off;
    int                w_rx_off;
    logic              w_dac_bit;
    logic              w_rx_in_win;

    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_cur_l;
    logic [DATA_W-1:0] r_cur_r;
    audio_mode_e       r_mode_q;
    logic              r_dac;
    logic [DATA_W-1:0] r_rx_sh_l;
    logic [DATA_W-1:0] r_rx_sh_r;
    logic [DATA_W-1:0] r_rx_l;
    logic [DATA_W-1:0] r_rx_r;
    logic              r_rx_valid;
    logic              r_underrun;
    logic              r_rx_arm;

    audio_bclk_lrck_gen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV),
        .CNT_W    (CNT_W)
    ) u_gen (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_en        (en_i),
        .o_bclk      (w_bclk),
        .o_ch        (w_ch),
        .o_bit_cnt   (w_bit_cnt),
        .o_bit_nxt   (w_bit_nxt),
        .o_ch_nxt    (w_ch_nxt),
        .o_rise_stb  (w_rise),
        .o_fall_stb  (w_fall),
        .o_frame_stb (w_frame)
    );

    assign w_accept = tx_valid_i && !r_hold_full;

    // The DAC bit for slot index 0 is launched on the frame-start edge itself,
    // so it must see the incoming pair and mode rather than the registered ones.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_new_l     = r_cur_l;
        w_new_r     = r_cur_r;
        if (w_accept) begin
            w_new_l = tx_left_i;
            w_new_r = tx_right_i;
        end else if (r_hold_full) begin
            w_new_l = r_hold_l;
            w_new_r = r_hold_r;
        end

        w_mode_eff  = w_frame ? decode_mode(mode_i) : r_mode_q;
        if (w_ch_nxt) begin
            w_dac_word = w_frame ? w_new_r : r_cur_r;
        end else begin
            w_dac_word = w_frame ? w_new_l : r_cur_l;
        end
        w_dac_off   = int'(w_bit_nxt) - int'(msb_slot(w_mode_eff, DATA_W, SLOT_W));
        w_dac_shift = w_dac_word << w_dac_off;
        w_dac_bit   = 1'b0;
        if (w_dac_off >= 0 && w_dac_off < int'(DATA_W)) begin
            w_dac_bit = w_dac_shift[DATA_W-1];
        end

        w_rx_off    = int'(w_bit_cnt) - int'(msb_slot(r_mode_q, DATA_W, SLOT_W));
        w_rx_in_win = r_rx_arm && (w_rx_off >= 0) && (w_rx_off < int'(DATA_W));
    end

    // RX capture is armed only from the first frame start, so the first
    // rx_valid_o after reset always carries zeros.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_hold_full <= 1'b0;
            r_cur_l     <= '0;
            r_cur_r     <= '0;
            r_mode_q    <= MODE_I2S;
            r_dac       <= 1'b0;
            r_rx_sh_l   <= '0;
            r_rx_sh_r   <= '0;
            r_rx_l      <= '0;
            r_rx_r      <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_rx_arm    <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;

            if (w_frame) begin
                r_hold_full <= 1'b0;
                r_cur_l     <= w_new_l;
                r_cur_r     <= w_new_r;
                r_mode_q    <= decode_mode(mode_i);
                r_underrun  <= !w_accept && !r_hold_full;
                r_rx_l      <= r_rx_sh_l;
                r_rx_r      <= r_rx_sh_r;
                r_rx_valid  <= 1'b1;
                r_rx_arm    <= 1'b1;
            end else if (w_accept) begin
                r_hold_l    <= tx_left_i;
                r_hold_r    <= tx_right_i;
                r_hold_full <= 1'b1;
            end

            if (w_fall) begin
                r_dac <= w_dac_bit;
            end

            if (w_rise && w_rx_in_win) begin
                if (w_ch) begin
                    r_rx_sh_r <= {r_rx_sh_r[DATA_W-2:0], codec_adc_dat_i};
                end else begin
                    r_rx_sh_l <= {r_rx_sh_l[DATA_W-2:0], codec_adc_dat_i};
                end
            end
        end
    end

    assign tx_ready_o      = !r_hold_full;
    assign rx_left_o       = r_rx_l;
    assign rx_right_o      = r_rx_r;
    assign rx_valid_o      = r_rx_valid;
    assign underrun_o      = r_underrun;
    assign codec_bclk_o    = w_bclk;
    assign codec_lrck_o    = w_ch;
    assign codec_dac_dat_o = r_dac;

endmodule
